// File: rtl/barrel_shifter_if.sv
// rtl/barrel_shifter_if.sv - data and shift-select bundle for barrel_shifter
interface barrel_shifter_if #(
   parameter int WIDTH = 8
);
   logic [0:WIDTH-1] Ip;
   logic [0:4]       shift_mag;
   logic [0:WIDTH-1] Op;
   logic             mag_err;

   modport master (
      output Ip,
      output shift_mag,
      input  Op,
      input  mag_err
   );

   modport slave (
      input  Ip,
      input  shift_mag,
      output Op,
      output mag_err
   );
endinterface

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - registered logical shifter, one-hot magnitude select
module barrel_shifter #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   barrel_shifter_if.slave   bus
);

   logic [0:WIDTH-1] w_shifted;
   logic             w_err;
   logic [0:WIDTH-1] r_op;
   logic             r_err;

   // Index 0 is the MSB, so a right shift moves bits toward higher indices.
   always_comb begin
      w_shifted = bus.Ip;
      w_err     = 1'b0;
      case (bus.shift_mag)
         5'b10000: w_shifted = {2'b00, bus.Ip[0:WIDTH-3]};
         5'b01000: w_shifted = {1'b0, bus.Ip[0:WIDTH-2]};
         5'b00100: w_shifted = bus.Ip;
         5'b00010: w_shifted = {bus.Ip[1:WIDTH-1], 1'b0};
         5'b00001: w_shifted = {bus.Ip[2:WIDTH-1], 2'b00};
         5'b00000: w_shifted = bus.Ip;
         default:  w_err     = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op  <= '0;
         r_err <= 1'b0;
      end else begin
         r_op  <= w_shifted;
         r_err <= w_err;
      end
   end

   assign bus.Op      = r_op;
   assign bus.mag_err = r_err;

endmodule

// File: tb/tb_barrel_shifter.sv
// tb/tb_barrel_shifter.sv - directed and randomized checks of barrel_shifter
module tb_barrel_shifter;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   barrel_shifter_if #(.WIDTH(8)) bif ();

   barrel_shifter #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model(input logic [7:0] ip, input logic [4:0] mag,
                                 output logic [7:0] op, output logic err);
      int v;
      v   = int'(ip);
      err = ($countones(mag) > 1);
      op  = ip;
      if (!err) begin
         if (mag == 5'b10000) v = v / 4;
         else if (mag == 5'b01000) v = v / 2;
         else if (mag == 5'b00010) v = (v * 2) % 256;
         else if (mag == 5'b00001) v = (v * 4) % 256;
         op = v[7:0];
      end
   endfunction

   task automatic check(input string name, input logic [7:0] exp_op, input logic exp_err);
      logic [7:0] act;
      act = bif.Op;
      tests++;
      if (act !== exp_op || bif.mag_err !== exp_err) begin
         fails++;
         $display("FAIL %s: got Op=%h mag_err=%b, expected Op=%h mag_err=%b",
                  name, act, bif.mag_err, exp_op, exp_err);
      end
   endtask

   task automatic apply(input logic [7:0] ip, input logic [4:0] mag);
      @(negedge clk);
      bif.Ip        = ip;
      bif.shift_mag = mag;
      @(posedge clk);
      #1;
   endtask

   // Every clean cycle the DUT output is compared to the numeric model.
   initial begin
      logic [7:0] s_ip;
      logic [4:0] s_mag;
      logic [7:0] e_op;
      logic       e_err;
      forever begin
         @(posedge clk);
         s_ip  = bif.Ip;
         s_mag = bif.shift_mag;
         if (!rst) begin
            #1;
            if (!rst) begin
               model(s_ip, s_mag, e_op, e_err);
               check("model", e_op, e_err);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r_ip;
      logic [4:0] r_mag;
      logic [4:0] legal [6];
      tests = 0;
      fails = 0;
      legal[0] = 5'b10000; legal[1] = 5'b01000; legal[2] = 5'b00100;
      legal[3] = 5'b00010; legal[4] = 5'b00001; legal[5] = 5'b00000;

      rst           = 1'b1;
      bif.Ip        = 8'b1111_1111;
      bif.shift_mag = 5'b00100;
      #1;
      check("reset_immediate", 8'h00, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_held", 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_release_hold", 8'h00, 1'b0);
      @(posedge clk);
      #1;
      check("first_after_reset", 8'b1111_1111, 1'b0);

      apply(8'b0000_0000, 5'b00000); check("idle_zero", 8'h00, 1'b0);
      apply(8'b0000_0000, 5'b00100); check("pass_zero", 8'h00, 1'b0);
      apply(8'b1010_1101, 5'b00100); check("pass_ad", 8'b1010_1101, 1'b0);
      apply(8'b0000_0001, 5'b00010); check("left1_01", 8'b0000_0010, 1'b0);
      apply(8'b0000_0010, 5'b00010); check("left1_02", 8'b0000_0100, 1'b0);
      apply(8'b1010_1101, 5'b00001); check("left2_ad", 8'b1011_0100, 1'b0);

      @(negedge clk);
      bif.shift_mag = 5'b10000;
      #1;
      check("latency_hold", 8'b1011_0100, 1'b0);
      @(posedge clk);
      #1;
      check("right2_ad", 8'b0010_1011, 1'b0);

      apply(8'b1010_1101, 5'b01000); check("right1_ad", 8'b0101_0110, 1'b0);
      apply(8'b1000_0001, 5'b00001); check("left2_drop", 8'b0000_0100, 1'b0);
      apply(8'b1000_0001, 5'b10000); check("right2_drop", 8'b0010_0000, 1'b0);
      apply(8'b1100_0011, 5'b10001); check("illegal", 8'b1100_0011, 1'b1);
      apply(8'b1100_0011, 5'b00100); check("illegal_clear", 8'b1100_0011, 1'b0);
      apply(8'b0000_0000, 5'b11111); check("illegal_zero", 8'h00, 1'b1);

      // Asynchronous clear in the middle of a cycle, then a fresh load.
      apply(8'b1100_0011, 5'b01100);
      #2;
      rst = 1'b1;
      #1;
      check("reset_mid", 8'h00, 1'b0);
      @(negedge clk);
      rst           = 1'b0;
      bif.Ip        = 8'b0110_0110;
      bif.shift_mag = 5'b00010;
      @(posedge clk);
      #1;
      check("reset_mid_reload", 8'b1100_1100, 1'b0);

      for (int i = 0; i < 400; i++) begin
         r_ip = 8'($urandom);
         if ($urandom_range(0, 3) == 0) r_mag = 5'($urandom);
         else r_mag = legal[$urandom_range(0, 5)];
         apply(r_ip, r_mag);
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
